// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared constants and types for the ALU control unit
// Instruction layout: OPCODE[31:24] DEST[23:16] SRC1[15:8] SRC2/IMM[7:0].
// Register addresses use the low REG_ADDR_W bits of each byte field.
package cu_pkg;

   localparam int INSTR_W    = 32;
   localparam int DATA_W     = 8;
   localparam int REG_ADDR_W = 3;

   localparam int OPC_LSB  = 24;
   localparam int DEST_LSB = 16;
   localparam int SRC1_LSB = 8;
   localparam int SRC2_LSB = 0;

   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   localparam logic [7:0] OP_LWD   = 8'h08;
   localparam logic [7:0] OP_LWI   = 8'h09;
   localparam logic [7:0] OP_SWD   = 8'h0A;
   localparam logic [7:0] OP_SWI   = 8'h0B;
   localparam logic [7:0] OP_BNE   = 8'h0D;

   localparam logic [2:0] ALU_FWD = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   typedef enum logic [2:0] {
      ST_IDLE, ST_EXEC, ST_MEM, ST_WB, ST_BR
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU, CLS_LOAD, CLS_STORE, CLS_JUMP, CLS_BRANCH, CLS_BAD
   } op_class_t;

endpackage

// File: rtl/cu_opcode_decoder.sv
// rtl/cu_opcode_decoder.sv - combinational opcode decoder for the control unit
// Build option: CU_BRANCH_EN adds beq (07) / bne (0D); otherwise they decode as BAD.
// Ports:
//   opcode      in   8  instruction opcode byte
//   alu_select  out  3  ALU function code
//   imm_sel     out  1  ALU DATA2 taken from the immediate
//   neg_sel     out  1  negate ALU DATA2
//   op_class    out     sequencing class consumed by the FSM
module cu_opcode_decoder
   import cu_pkg::*;
(
   input  logic [7:0] opcode,
   output logic [2:0] alu_select,
   output logic       imm_sel,
   output logic       neg_sel,
   output op_class_t  op_class
);

   always_comb begin
      alu_select = ALU_FWD;
      imm_sel    = 1'b0;
      neg_sel    = 1'b0;
      op_class   = CLS_BAD;
      case (opcode)
         OP_LOADI: begin op_class = CLS_ALU; imm_sel = 1'b1; end
         OP_MOV:   begin op_class = CLS_ALU; end
         OP_ADD:   begin op_class = CLS_ALU; alu_select = ALU_ADD; end
         OP_SUB:   begin op_class = CLS_ALU; alu_select = ALU_ADD; neg_sel = 1'b1; end
         OP_AND:   begin op_class = CLS_ALU; alu_select = ALU_AND; end
         OP_OR:    begin op_class = CLS_ALU; alu_select = ALU_OR; end
         OP_J:     begin op_class = CLS_JUMP; end
         OP_LWD:   begin op_class = CLS_LOAD; end
         OP_LWI:   begin op_class = CLS_LOAD; imm_sel = 1'b1; end
         OP_SWD:   begin op_class = CLS_STORE; end
         OP_SWI:   begin op_class = CLS_STORE; imm_sel = 1'b1; end
`ifdef CU_BRANCH_EN
         // Compare by subtraction: ALU computes SRC1 + (-SRC2), ZERO flags equality.
         OP_BEQ, OP_BNE: begin
            op_class   = CLS_BRANCH;
            alu_select = ALU_ADD;
            neg_sel    = 1'b1;
         end
`endif
         default: op_class = CLS_BAD;
      endcase
   end

endmodule

// File: rtl/alu_control_fsm.sv
// rtl/alu_control_fsm.sv - multi-cycle control unit sequencing EXEC/MEM/WB/BR
// Build option: CU_BRANCH_EN enables beq/bne (ALU_ZERO sampled at the end of EXEC).
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   instr, instr_valid/ready      instruction handshake from fetch (ready only in IDLE)
//   alu_select, imm_sel, neg_sel  ALU controls, valid during EXEC
//   read_reg1/2, write_reg, imm   register-file addresses and immediate, held per instruction
//   reg_write_en                  one-cycle write strobe in WB
//   mem_read, mem_write           data-memory requests held through MEM
//   mem_busywait                  memory stall, only observed in MEM
//   alu_zero                      ALU ZERO flag for branches
//   pc_branch, illegal            one-cycle pulses
module alu_control_fsm
   import cu_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [INSTR_W-1:0]    instr,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   output logic [2:0]            alu_select,
   output logic                  imm_sel,
   output logic                  neg_sel,
   output logic [REG_ADDR_W-1:0] read_reg1,
   output logic [REG_ADDR_W-1:0] read_reg2,
   output logic [REG_ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0]     imm,
   output logic                  reg_write_en,
   output logic                  mem_read,
   output logic                  mem_write,
   input  logic                  mem_busywait,
   input  logic                  alu_zero,
   output logic                  pc_branch,
   output logic                  illegal
);

   state_t    state_q, state_d;
   op_class_t cls_q, dec_class;
   logic [2:0] dec_alu;
   logic      dec_imm_sel, dec_neg_sel;
   logic      accept, take;
   logic      ready_d, rwe_d, mem_read_d, mem_write_d, pc_branch_d, illegal_d;

   // instr_ready is high exactly when the state register holds IDLE.
   assign accept = instr_valid & instr_ready;

   cu_opcode_decoder u_dec (
      .opcode     (instr[OPC_LSB +: 8]),
      .alu_select (dec_alu),
      .imm_sel    (dec_imm_sel),
      .neg_sel    (dec_neg_sel),
      .op_class   (dec_class)
   );

`ifdef CU_BRANCH_EN
   logic bne_q;
   logic unused_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    bne_q <= 1'b0;
      else if (accept) bne_q <= (instr[OPC_LSB +: 8] == OP_BNE);
   end

   // Only meaningful while in EXEC: alu_zero is live there and is captured
   // into pc_branch by the EXEC->BR edge.
   assign take = (cls_q == CLS_JUMP) | ((cls_q == CLS_BRANCH) & (alu_zero ^ bne_q));
   assign unused_ok = &{1'b0, instr[DEST_LSB+7:DEST_LSB+REG_ADDR_W],
                        instr[SRC1_LSB+7:SRC1_LSB+REG_ADDR_W]};
`else
   logic unused_ok;

   assign take = (cls_q == CLS_JUMP);
   assign unused_ok = &{1'b0, alu_zero, instr[DEST_LSB+7:DEST_LSB+REG_ADDR_W],
                        instr[SRC1_LSB+7:SRC1_LSB+REG_ADDR_W]};
`endif

   // Instruction fields and decoded ALU controls, frozen at accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cls_q      <= CLS_BAD;
         alu_select <= ALU_FWD;
         imm_sel    <= 1'b0;
         neg_sel    <= 1'b0;
         read_reg1  <= '0;
         read_reg2  <= '0;
         write_reg  <= '0;
         imm        <= '0;
      end else if (accept) begin
         cls_q      <= dec_class;
         alu_select <= dec_alu;
         imm_sel    <= dec_imm_sel;
         neg_sel    <= dec_neg_sel;
         read_reg1  <= instr[SRC1_LSB +: REG_ADDR_W];
         read_reg2  <= instr[SRC2_LSB +: REG_ADDR_W];
         write_reg  <= instr[DEST_LSB +: REG_ADDR_W];
         imm        <= instr[SRC2_LSB +: DATA_W];
      end
   end

   // Next state, and the strobes derived from it so they can be registered
   // alongside the state (outputs then change only on clock or reset).
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (instr_valid) state_d = ST_EXEC;
         ST_EXEC: begin
            case (cls_q)
               CLS_ALU:             state_d = ST_WB;
               CLS_LOAD, CLS_STORE: state_d = ST_MEM;
               CLS_JUMP, CLS_BRANCH: state_d = ST_BR;
               default:             state_d = ST_IDLE;
            endcase
         end
         ST_MEM:  if (!mem_busywait) state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      ready_d     = (state_d == ST_IDLE);
      rwe_d       = (state_d == ST_WB);
      mem_read_d  = (state_d == ST_MEM) & (cls_q == CLS_LOAD);
      mem_write_d = (state_d == ST_MEM) & (cls_q == CLS_STORE);
      pc_branch_d = (state_d == ST_BR) & take;
      // EXEC is entered only from IDLE, so the live decode is the new instruction.
      illegal_d   = (state_d == ST_EXEC) & (dec_class == CLS_BAD);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         instr_ready  <= 1'b1;
         reg_write_en <= 1'b0;
         mem_read     <= 1'b0;
         mem_write    <= 1'b0;
         pc_branch    <= 1'b0;
         illegal      <= 1'b0;
      end else begin
         state_q      <= state_d;
         instr_ready  <= ready_d;
         reg_write_en <= rwe_d;
         mem_read     <= mem_read_d;
         mem_write    <= mem_write_d;
         pc_branch    <= pc_branch_d;
         illegal      <= illegal_d;
      end
   end

endmodule

// File: tb/tb_alu_control_fsm.sv
// tb/tb_alu_control_fsm.sv - scoreboard bench for alu_control_fsm
module tb_alu_control_fsm;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] instr;
   logic        instr_valid, instr_ready;
   logic [2:0]  alu_select;
   logic        imm_sel, neg_sel;
   logic [2:0]  read_reg1, read_reg2, write_reg;
   logic [7:0]  imm;
   logic        reg_write_en, mem_read, mem_write, mem_busywait, alu_zero;
   logic        pc_branch, illegal;

   always #5 clk = ~clk;

   alu_control_fsm dut (
      .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .alu_select(alu_select), .imm_sel(imm_sel),
      .neg_sel(neg_sel), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .write_reg(write_reg), .imm(imm), .reg_write_en(reg_write_en),
      .mem_read(mem_read), .mem_write(mem_write), .mem_busywait(mem_busywait),
      .alu_zero(alu_zero), .pc_branch(pc_branch), .illegal(illegal)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Transaction-level expectation: cycles with ready low, strobe counts, controls.
   typedef struct {
      int occ; int rwe; int wreg; int mr; int mw; int pcb; int ill;
      bit chk_alu; int alu; int neg;
      bit chk_isel; int isel;
      bit chk_imm; int imm;
      int rr1; int rr2;
   } exp_t;

   exp_t exp_q[$];

   function automatic exp_t model(input logic [31:0] ins, input bit zero, input int nb);
      exp_t e;
      int op;
      int m;
      op = int'(ins[31:24]);
      m  = nb + 1;                     // memory holds busy nb cycles, then one ready cycle
      e = '{default: 0};
      e.wreg = int'(ins[18:16]);
      e.rr1  = int'(ins[10:8]);
      e.rr2  = int'(ins[2:0]);
      e.imm  = int'(ins[7:0]);
      case (op)
         0, 1, 2, 3, 4, 5: begin
            e.occ = 2; e.rwe = 1;
            e.chk_alu = 1;
            e.alu = (op == 4) ? 2 : (op == 5) ? 3 : (op == 2 || op == 3) ? 1 : 0;
            e.neg = (op == 3) ? 1 : 0;
            e.chk_isel = 1; e.isel = (op == 0) ? 1 : 0;
            e.chk_imm = (op == 0);
         end
         8, 9: begin
            e.occ = 2 + m; e.rwe = 1; e.mr = m;
            e.chk_isel = 1; e.isel = (op == 9) ? 1 : 0;
            e.chk_imm = (op == 9);
         end
         10, 11: begin
            e.occ = 1 + m; e.mw = m;
            e.chk_isel = 1; e.isel = (op == 11) ? 1 : 0;
            e.chk_imm = (op == 11);
         end
         6: begin
            e.occ = 2; e.pcb = 1; e.chk_imm = 1;
         end
`ifdef CU_BRANCH_EN
         7, 13: begin
            e.occ = 2;
            e.pcb = (op == 7) ? int'(zero) : int'(!zero);
            e.chk_alu = 1; e.alu = 1; e.neg = 1;
            e.chk_isel = 1; e.isel = 0;
            e.chk_imm = 1;
         end
`endif
         default: begin
            e.occ = 1; e.ill = 1;
         end
      endcase
      return e;
   endfunction

   // Data memory responder: busy for acc_busy cycles of each MEM visit, random noise otherwise.
   int acc_busy = 0;
   int mem_cnt = 0;
   initial begin
      mem_busywait = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_read || mem_write) begin
            mem_busywait = (mem_cnt < acc_busy);
            mem_cnt++;
         end else begin
            mem_busywait = 1'($urandom % 2);
            mem_cnt = 0;
         end
      end
   end

   // Monitor: a transaction spans the negedges where instr_ready is low.
   bit mon_en = 0;
   initial begin
      bit in_txn;
      int o_occ, o_rwe, o_wreg, o_mr, o_mw, o_pcb, o_ill, o_alu, o_neg, o_isel, o_imm, o_rr1, o_rr2;
      exp_t e;
      in_txn = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            in_txn = 0;
         end else if (in_txn && instr_ready) begin
            in_txn = 0;
            if (exp_q.size() == 0) begin
               chk("unexpected_txn", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("occupancy", o_occ, e.occ);
               chk("reg_write_en_pulses", o_rwe, e.rwe);
               if (e.rwe > 0) chk("write_reg", o_wreg, e.wreg);
               chk("mem_read_cycles", o_mr, e.mr);
               chk("mem_write_cycles", o_mw, e.mw);
               chk("pc_branch_pulses", o_pcb, e.pcb);
               chk("illegal_pulses", o_ill, e.ill);
               if (e.chk_alu) begin
                  chk("alu_select", o_alu, e.alu);
                  chk("neg_sel", o_neg, e.neg);
               end
               if (e.chk_isel) chk("imm_sel", o_isel, e.isel);
               if (e.chk_imm) chk("imm", o_imm, e.imm);
               chk("read_reg1", o_rr1, e.rr1);
               chk("read_reg2", o_rr2, e.rr2);
               chk("idle_quiet", {reg_write_en, mem_read, mem_write, pc_branch, illegal}, 0);
            end
         end else if (!instr_ready) begin
            if (!in_txn) begin
               in_txn = 1;
               o_occ = 0; o_rwe = 0; o_wreg = -1; o_mr = 0; o_mw = 0; o_pcb = 0; o_ill = 0;
               o_alu = int'(alu_select); o_neg = int'(neg_sel); o_isel = int'(imm_sel);
               o_imm = int'(imm); o_rr1 = int'(read_reg1); o_rr2 = int'(read_reg2);
            end
            o_occ++;
            o_mr  += int'(mem_read);
            o_mw  += int'(mem_write);
            o_pcb += int'(pc_branch);
            o_ill += int'(illegal);
            if (reg_write_en) begin
               o_rwe++;
               o_wreg = int'(write_reg);
            end
            if (o_occ > 200) begin
               chk("txn_timeout", 1, 0);
               in_txn = 0;
            end
         end
      end
   end

   // Present one instruction as soon as the unit is idle; valid stays high afterwards.
   task automatic issue(input logic [31:0] ins, input bit z, input int nb, input int gap);
      int t;
      repeat (gap) begin
         @(negedge clk);
         instr_valid = 1'b0;
      end
      @(negedge clk);
      t = 0;
      while (!instr_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!instr_ready) begin
         chk("ready_timeout", 0, 1);
      end else begin
         instr       = ins;
         alu_zero    = z;
         acc_busy    = nb;
         instr_valid = 1'b1;
         exp_q.push_back(model(ins, z, nb));
         @(posedge clk);
      end
   endtask

   initial begin
      logic [31:0] rnd;
      logic [7:0]  op8;
      int t;

      reset_n = 1'b0; instr = '0; instr_valid = 1'b0; alu_zero = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_ready", instr_ready, 1);
      chk("reset_outputs", {alu_select, imm_sel, neg_sel, read_reg1, read_reg2, write_reg,
                            imm, reg_write_en, mem_read, mem_write, pc_branch, illegal}, 0);
      reset_n = 1'b1;
      mon_en  = 1;

      issue(32'h02030102, 1'b0, 0, 0);   // add, valid held high
      issue(32'h000400FF, 1'b0, 0, 0);   // loadi 0xFF
      issue(32'h08050102, 1'b0, 3, 1);   // lwd, 3 busy cycles
      issue(32'h07000112, 1'b1, 0, 0);   // beq, zero=1
      issue(32'h07000234, 1'b0, 0, 0);   // beq, zero=0
      issue(32'h0D000356, 1'b0, 0, 0);   // bne, zero=0
      issue(32'hFF000000, 1'b0, 0, 0);   // undefined
      issue(32'h06000080, 1'b0, 0, 2);   // j
      issue(32'h0A000102, 1'b0, 2, 0);   // swd

      for (int i = 0; i < 300; i++) begin
         rnd = $urandom;
         if ($urandom % 5 == 0) op8 = rnd[31:24];
         else                   op8 = 8'($urandom % 14);
         issue({op8, rnd[23:0]}, 1'($urandom % 2), int'($urandom % 4), int'($urandom % 3));
      end

      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("scoreboard_drain", exp_q.size(), 0);
      mon_en = 0;

      // Reset in the middle of a stalled store.
      issue(32'h0A000102, 1'b0, 20, 1);
      @(negedge clk);
      instr_valid = 1'b0;
      t = 0;
      while (!mem_write && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("swd_mem_write_up", mem_write, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_mem_write_drop", mem_write, 0);
      chk("async_ready", instr_ready, 1);
      chk("async_other_strobes", {mem_read, reg_write_en, pc_branch, illegal}, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_reset_ready", instr_ready, 1);
         chk("post_reset_quiet", {reg_write_en, mem_read, mem_write, pc_branch, illegal}, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
